serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial N-bit adder that sits directly upstream of, and is built from, the
//   team's half_adder cell. One full-adder slice is formed from two half_adder
//   instances plus an OR of their carries, with a carry flip-flop between cycles.
//   Operands are accepted over a valid/ready handshake and added LSB-first, one bit
//   per clock. The sum and carry-out are returned over a second valid/ready handshake.
// PARAMETERS
//   WIDTH  8  operand and sum width in bits; legal range is WIDTH >= 2
// PORTS
//   clk        in   1      system clock; all state changes on its rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      a_in/b_in hold a valid operand pair
//   in_ready   out  1      block can accept an operand pair (high only in IDLE)
//   a_in       in   WIDTH  operand A, unsigned
//   b_in       in   WIDTH  operand B, unsigned
//   out_valid  out  1      sum_out/cout_out hold a completed result
//   out_ready  in   1      downstream consumes the result
//   sum_out    out  WIDTH  (a_in + b_in) mod 2^WIDTH
//   cout_out   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset (rst_n low, takes effect asynchronously)
//     - state=IDLE; shift registers, carry flop, bit counter, sum_out, cout_out all 0.
//     - out_valid=0; in_ready=1, since it is decoded directly from state==IDLE.
//   FSM
//     IDLE -> ADD   when in_valid & in_ready.
//                   That edge loads A<=a_in, B<=b_in, carry<=0, cnt<=0, and clears the result shift register.
//     ADD           each edge: s=A[0]^B[0]^carry; carry<=maj(A[0],B[0],carry);
//                   A,B shift right one bit; s shifts into result MSB (result shifts right); cnt<=cnt+1.
//     ADD -> HOLD   on the edge where cnt==WIDTH-1, i.e. after WIDTH add edges.
//                   That edge also loads sum_out<={s,result[WIDTH-1:1]} and cout_out<=final carry.
//     HOLD -> IDLE  when out_ready; out_valid=1 throughout HOLD.
//   Latency and throughput
//     - Acceptance at edge k gives out_valid high after edge k+WIDTH.
//     - Minimum spacing between acceptances is WIDTH+2 cycles.
//   Boundary conditions
//     - in_valid outside IDLE is ignored; operands are not sampled and no state changes.
//     - out_ready while out_valid=0 is ignored.
//     - In HOLD with out_ready=0 (backpressure), sum_out, cout_out and out_valid stay stable indefinitely.
//     - sum_out and cout_out change only on the ADD->HOLD edge or on reset. Between results they keep the last value.
//     - cnt width is $clog2(WIDTH). There is no wrap-around hazard because cnt is reloaded on each acceptance.
//     - Reset asserted mid-ADD or mid-HOLD aborts the operation: the in-flight result is lost and out_valid is never raised for it.
//     - A full carry ripple (e.g. all-ones + 1) needs no extra cycle; cout_out is captured on the same edge as the last sum bit.
// TESTING (WIDTH=8 unless noted)
//   1. Reset: rst_n=0 for 3 cycles mid-stream.
//      -> out_valid=0, in_ready=1, sum_out=8'h00, cout_out=0.
//   2. Basic add: a_in=8'h35, b_in=8'h4A, out_ready=1.
//      -> out_valid rises 8 cycles after acceptance with sum_out=8'h7F, cout_out=0.
//   3. Ripple carry: a_in=8'hFF, b_in=8'h01.
//      -> sum_out=8'h00, cout_out=1; then 8'h80+8'h80 -> sum_out=8'h00, cout_out=1.
//   4. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and drive in_valid=1 with new operands throughout.
//      -> result stable, in_ready=0, new operands ignored.
//      -> out_ready=1 gives out_valid=0 and in_ready=1 on the next cycle.
//   5. Abort: pulse rst_n low on the 3rd ADD cycle.
//      -> no out_valid for that pair; the next pair 8'h12+8'h34 returns 8'h46, cout_out=0.
//   6. Random: 1000 back-to-back pairs with random out_ready, at WIDTH=8 and WIDTH=16.
//      -> every {cout_out,sum_out} equals a_in+b_in from a reference model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// half_adder / serial_adder
//
// half_adder: the single-bit building block. sum = a ^ b, carry = a & b.
//
// serial_adder: bit-serial WIDTH-bit unsigned adder. One full-adder slice is
// built from two half_adder cells plus an OR of their carries, and a carry
// flop links successive bit positions. Operands arrive over a valid/ready
// handshake and are added LSB-first, one bit per clock. The WIDTH-bit sum and
// the carry out of the top bit are returned over a second valid/ready
// handshake.
//
// Ports (serial_adder):
//   clk        in   1      system clock, rising-edge active
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a_in/b_in hold a valid operand pair
//   in_ready   out  1      operand pair can be accepted (high only in IDLE)
//   a_in       in   WIDTH  operand A, unsigned
//   b_in       in   WIDTH  operand B, unsigned
//   out_valid  out  1      sum_out/cout_out hold a completed result
//   out_ready  in   1      downstream consumes the result
//   sum_out    out  WIDTH  (a_in + b_in) mod 2^WIDTH
//   cout_out   out  1      carry out of bit WIDTH-1
// -----------------------------------------------------------------------------

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic ha0_sum;
   logic ha0_carry;
   logic bit_sum;
   logic ha1_carry;
   logic bit_carry;

   // Full-adder slice: first cell adds the operand bits, second folds in the
   // carry from the previous bit. Both carries can never be high together,
   // so OR-ing them gives the majority function.
   half_adder u_ha0 (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .sum   (ha0_sum),
      .carry (ha0_carry)
   );

   half_adder u_ha1 (
      .a     (ha0_sum),
      .b     (carry_q),
      .sum   (bit_sum),
      .carry (ha1_carry)
   );

   assign bit_carry = ha0_carry | ha1_carry;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign sum_out   = sum_q;
   assign cout_out  = cout_q;

   // Next-state and datapath: operands shift right so bit 0 always feeds the
   // slice, and each new sum bit enters the result from the top. The result
   // registers are only written on the final add edge, so they hold the last
   // answer for as long as nobody starts and finishes another one.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = ADD;
               a_d     = a_in;
               b_d     = b_in;
               carry_d = 1'b0;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         ADD: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = bit_carry;
            res_d   = {bit_sum, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = HOLD;
               sum_d   = {bit_sum, res_q[WIDTH-1:1]};
               cout_d  = bit_carry;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset clears everything, so an in-flight add is simply
   // abandoned and never produces a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder: drives an 8-bit and a 16-bit serial_adder. The 8-bit unit
// gets directed vectors and multi-cycle corner sequences followed by a random
// run; the 16-bit unit runs a random stream in parallel. Random results are
// checked against a queue of plain-arithmetic sums.
// -----------------------------------------------------------------------------

module tb_serial_adder;

   logic clk;

   logic        rst_n8;
   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  sum8;
   logic        cout8;

   logic        rst_n16;
   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] sum16;
   logic        cout16;

   logic done16;
   int   compared;
   int   mismatched;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs[7];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n8),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a_in      (a8),
      .b_in      (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum_out   (sum8),
      .cout_out  (cout8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n16),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a_in      (a16),
      .b_in      (b16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .sum_out   (sum16),
      .cout_out  (cout16)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Offer one pair to the 8-bit unit, wait for acceptance, then count edges
   // until out_valid rises. out_ready is left untouched.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
      int guard;
      @(negedge clk);
      a8 = a;
      b8 = b;
      in_valid8 = 1'b1;
      guard = 0;
      while (!in_ready8 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Consume the current result with a one-cycle out_ready pulse.
   task automatic releaseResult8(input string name);
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
      checkOutput({name, "_valid_drop"}, 32'(out_valid8), 32'd0);
      checkOutput({name, "_ready_back"}, 32'(in_ready8), 32'd1);
   endtask

   // Back-to-back random stream on the 8-bit unit; expected values come from
   // a queue of a+b sums pushed at acceptance and popped at each handshake.
   task automatic randomRun8(input int n);
      logic [8:0] q[$];
      logic [8:0] e;
      int acc;
      int rcv;
      int cyc;
      logic took;
      acc = 0;
      rcv = 0;
      cyc = 0;
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      in_valid8 = 1'b1;
      out_ready8 = 1'($urandom_range(0, 1));
      while (rcv < n && cyc < n * 40) begin
         took = 1'b0;
         if (in_valid8 && in_ready8) begin
            q.push_back({1'b0, a8} + {1'b0, b8});
            acc++;
            took = 1'b1;
         end
         if (out_valid8 && out_ready8) begin
            if (q.size() == 0) begin
               checkOutput("rand8_extra_result", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               checkOutput("rand8_result", 32'({cout8, sum8}), 32'(e));
            end
            rcv++;
         end
         @(posedge clk);
         #1;
         if (took) begin
            if (acc == n) begin
               in_valid8 = 1'b0;
            end else begin
               a8 = 8'($urandom);
               b8 = 8'($urandom);
            end
         end
         out_ready8 = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      out_ready8 = 1'b0;
      in_valid8 = 1'b0;
      checkOutput("rand8_count", 32'(rcv), 32'(n));
      checkOutput("rand8_leftover", 32'(q.size()), 32'd0);
   endtask

   // Same random stream for the 16-bit unit.
   task automatic randomRun16(input int n);
      logic [16:0] q[$];
      logic [16:0] e;
      int acc;
      int rcv;
      int cyc;
      logic took;
      acc = 0;
      rcv = 0;
      cyc = 0;
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      in_valid16 = 1'b1;
      out_ready16 = 1'($urandom_range(0, 1));
      while (rcv < n && cyc < 60000) begin
         took = 1'b0;
         if (in_valid16 && in_ready16) begin
            q.push_back({1'b0, a16} + {1'b0, b16});
            acc++;
            took = 1'b1;
         end
         if (out_valid16 && out_ready16) begin
            if (q.size() == 0) begin
               checkOutput("rand16_extra_result", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               checkOutput("rand16_result", 32'({cout16, sum16}), 32'(e));
            end
            rcv++;
         end
         @(posedge clk);
         #1;
         if (took) begin
            if (acc == n) begin
               in_valid16 = 1'b0;
            end else begin
               a16 = 16'($urandom);
               b16 = 16'($urandom);
            end
         end
         out_ready16 = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      out_ready16 = 1'b0;
      in_valid16 = 1'b0;
      checkOutput("rand16_count", 32'(rcv), 32'(n));
      checkOutput("rand16_leftover", 32'(q.size()), 32'd0);
   endtask

   // 16-bit unit: reset, then random stream, then flag completion.
   initial begin
      done16 = 1'b0;
      rst_n16 = 1'b0;
      in_valid16 = 1'b0;
      out_ready16 = 1'b0;
      a16 = '0;
      b16 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n16 = 1'b1;
      randomRun16(1000);
      done16 = 1'b1;
   end

   // 8-bit unit: directed tests, corner sequences, random run, summary.
   initial begin
      int lat;
      int guard;
      logic seen;

      vecs[0] = '{"basic_35_4a",  8'h35, 8'h4A, 8'h7F, 1'b0};
      vecs[1] = '{"ripple_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{"msb_80_80",    8'h80, 8'h80, 8'h00, 1'b1};
      vecs[3] = '{"zero_00_00",   8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{"max_ff_ff",    8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[5] = '{"alt_aa_55",    8'hAA, 8'h55, 8'hFF, 1'b0};
      vecs[6] = '{"mid_7f_01",    8'h7F, 8'h01, 8'h80, 1'b0};

      compared = 0;
      mismatched = 0;
      rst_n8 = 1'b0;
      in_valid8 = 1'b0;
      out_ready8 = 1'b0;
      a8 = '0;
      b8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n8 = 1'b1;

      // Reset held for three cycles in the middle of an add.
      @(negedge clk);
      a8 = 8'hFF;
      b8 = 8'hFF;
      in_valid8 = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid8), 32'd0);
      checkOutput("reset_in_ready",  32'(in_ready8),  32'd1);
      checkOutput("reset_sum",       32'(sum8),       32'h00);
      checkOutput("reset_cout",      32'(cout8),      32'd0);
      @(negedge clk);
      rst_n8 = 1'b1;

      // Table-driven vectors, each with latency, result and release checks.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat);
         checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd8);
         checkOutput({vecs[i].name, "_sum"},  32'(sum8),  32'(vecs[i].sum));
         checkOutput({vecs[i].name, "_cout"}, 32'(cout8), 32'(vecs[i].cout));
         releaseResult8(vecs[i].name);
      end

      // Backpressure: result held while new operands are offered and ignored.
      applyStimulus(8'hC3, 8'h5A, lat);
      checkOutput("bp_latency", 32'(lat), 32'd8);
      @(negedge clk);
      a8 = 8'h11;
      b8 = 8'h22;
      in_valid8 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_sum",       32'(sum8),       32'h1D);
         checkOutput("bp_cout",      32'(cout8),      32'd1);
         checkOutput("bp_out_valid", 32'(out_valid8), 32'd1);
         checkOutput("bp_in_ready",  32'(in_ready8),  32'd0);
      end
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      out_ready8 = 1'b0;
      checkOutput("bp_release_valid", 32'(out_valid8), 32'd0);
      checkOutput("bp_release_ready", 32'(in_ready8),  32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_idle_ready", 32'(in_ready8), 32'd1);
      checkOutput("bp_keep_sum",   32'(sum8),      32'h1D);
      checkOutput("bp_keep_cout",  32'(cout8),     32'd1);

      // Abort: short reset pulse during the third add cycle.
      @(negedge clk);
      a8 = 8'hF0;
      b8 = 8'h0F;
      in_valid8 = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n8 = 1'b0;
      #2;
      rst_n8 = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid8) seen = 1'b1;
      end
      checkOutput("abort_no_valid", 32'(seen), 32'd0);
      checkOutput("abort_sum_clr",  32'(sum8), 32'h00);
      applyStimulus(8'h12, 8'h34, lat);
      checkOutput("abort_next_latency", 32'(lat),   32'd8);
      checkOutput("abort_next_sum",     32'(sum8),  32'h46);
      checkOutput("abort_next_cout",    32'(cout8), 32'd0);
      releaseResult8("abort_next");

      // Random stream on the 8-bit unit.
      randomRun8(1000);

      guard = 0;
      while (!done16 && guard < 70000) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("rand16_finished", 32'(done16), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
